// File: rtl/uart_disp_pkg.sv
// ---------------------------------------------------------------------------
// uart_disp_pkg
// Shared definitions for the UART word dispatcher: controller state encoding
// and the layout of the packet header byte.
//   Header bits [3:0] : destination channel id
//   Header bits [7:4] : number of words in the packet minus one
// ---------------------------------------------------------------------------
package uart_disp_pkg;

    typedef enum logic [1:0] {
        HDR      = 2'd0,
        DATA     = 2'd1,
        DISPATCH = 2'd2,
        DROP     = 2'd3
    } disp_state_t;

    localparam int HDR_CH_LSB  = 0;
    localparam int HDR_CH_W    = 4;
    localparam int HDR_CNT_LSB = 4;
    localparam int HDR_CNT_W   = 4;

    // Destination channel id carried in a header byte.
    function automatic logic [HDR_CH_W-1:0] hdr_channel(input logic [7:0] hdr);
        return hdr[HDR_CH_LSB +: HDR_CH_W];
    endfunction

    // Index of the last word of the packet (word count minus one).
    function automatic logic [HDR_CNT_W-1:0] hdr_last_word(input logic [7:0] hdr);
        return hdr[HDR_CNT_LSB +: HDR_CNT_W];
    endfunction

endpackage

// File: rtl/byte_edge_pending.sv
// ---------------------------------------------------------------------------
// byte_edge_pending
// Turns the receiver's level "byte ready" into a one-byte-deep pending flag.
// A rising edge on i_in_data_ready arms the flag; the flag is offered to the
// controller through o_valid whenever the controller can take a byte, and
// every accepted byte is acknowledged back to the receiver one cycle later.
// Ports:
//   i_clk           system clock
//   i_rst_n         asynchronous active-low reset
//   i_in_data_ready byte valid level from the receiver
//   i_consume_en    controller is in a state that accepts bytes
//   o_valid         a byte is being consumed this cycle
//   o_out_akn       one-cycle pulse: byte consumed
// ---------------------------------------------------------------------------
module byte_edge_pending (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in_data_ready,
    input  logic i_consume_en,
    output logic o_valid,
    output logic o_out_akn
);

    logic r_prev;
    logic r_pending;
    logic r_akn;
    logic w_rise;

    assign w_rise    = i_in_data_ready & ~r_prev;
    assign o_valid   = r_pending & i_consume_en;
    assign o_out_akn = r_akn;

    // A fresh edge arriving in the same cycle as a consume keeps the flag
    // set, so back-to-back bytes are never lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
            r_akn     <= 1'b0;
        end else begin
            r_prev    <= i_in_data_ready;
            r_pending <= w_rise | (r_pending & ~o_valid);
            r_akn     <= o_valid;
        end
    end

endmodule

// File: rtl/uart_word_dispatcher.sv
// ---------------------------------------------------------------------------
// uart_word_dispatcher
// Packet controller between a UART byte receiver and NCH word consumers.
// A header byte selects the destination channel and word count; the following
// bytes are packed LSB-first into BPW-byte words, and each finished word is
// offered to its channel with a ready/acknowledge handshake before assembly
// resumes. Packets for unknown channels and packets that stall for TIMEOUT
// cycles between bytes are dropped and flagged on o_pkt_err.
// Ports:
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_in_data_ready  byte valid level, new byte on its rising edge
//   i_byte_in        byte from receiver, stable until o_out_akn
//   o_out_akn        one-cycle pulse: byte consumed
//   o_ch_data_ready  one-hot: o_word_out valid for channel i
//   i_ch_akn         consumer i has taken o_word_out
//   o_word_out       assembled word, byte k in bits [8k+7:8k]
//   o_pkt_err        one-cycle pulse: packet dropped
//   o_busy           high whenever not waiting for a header
// ---------------------------------------------------------------------------
module uart_word_dispatcher
    import uart_disp_pkg::*;
#(
    parameter int BPW     = 4,
    parameter int NCH     = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_data_ready,
    input  logic [7:0]       i_byte_in,
    output logic             o_out_akn,
    output logic [NCH-1:0]   o_ch_data_ready,
    input  logic [NCH-1:0]   i_ch_akn,
    output logic [BPW*8-1:0] o_word_out,
    output logic             o_pkt_err,
    output logic             o_busy
);

    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int RW  = $clog2(16 * BPW + 1);

    disp_state_t r_state, w_state_nxt;

    logic [HDR_CH_W-1:0]  r_ch, w_ch_nxt;
    logic [HDR_CNT_W-1:0] r_last_word, w_last_word_nxt;
    logic [HDR_CNT_W-1:0] r_word_idx, w_word_idx_nxt;
    logic [BIW-1:0]       r_byte_idx, w_byte_idx_nxt;
    logic [RW-1:0]        r_remaining, w_remaining_nxt;
    logic [TW-1:0]        r_timer, w_timer_nxt, w_timer_inc;
    logic [BPW*8-1:0]     r_asm, w_asm_nxt;
    logic [BPW*8-1:0]     r_word, w_word_nxt;
    logic [NCH-1:0]       r_ch_ready, w_ch_ready_nxt, w_ch_mask;
    logic                 r_pkt_err, w_pkt_err_nxt;
    logic                 w_valid, w_consume_en, w_akn_hit;

    // Bytes are never taken while a word is waiting for its consumer; an edge
    // seen then simply stays pending until assembly resumes.
    assign w_consume_en = (r_state != DISPATCH);

    byte_edge_pending u_edge (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_in_data_ready (i_in_data_ready),
        .i_consume_en    (w_consume_en),
        .o_valid         (w_valid),
        .o_out_akn       (o_out_akn)
    );

    // One-hot mask of the addressed channel; only meaningful once the header
    // has been range checked.
    always_comb begin
        w_ch_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            w_ch_mask[i] = (int'(r_ch) == i);
        end
    end

    // Only an acknowledge against a word actually on offer counts, so an
    // acknowledge held high cannot pre-accept the next word.
    assign w_akn_hit = |(r_ch_ready & i_ch_akn);

    assign o_ch_data_ready = r_ch_ready;
    assign o_word_out      = r_word;
    assign o_pkt_err       = r_pkt_err;
    assign o_busy          = (r_state != HDR);

    // Next-state and datapath decode. A consumed byte always takes priority
    // over the idle timeout since it proves the packet is still alive.
    always_comb begin
        w_state_nxt     = r_state;
        w_ch_nxt        = r_ch;
        w_last_word_nxt = r_last_word;
        w_word_idx_nxt  = r_word_idx;
        w_byte_idx_nxt  = r_byte_idx;
        w_remaining_nxt = r_remaining;
        w_timer_nxt     = r_timer;
        w_asm_nxt       = r_asm;
        w_word_nxt      = r_word;
        w_ch_ready_nxt  = '0;
        w_pkt_err_nxt   = 1'b0;
        w_timer_inc     = r_timer + TW'(1);

        case (r_state)
            HDR: begin
                if (w_valid) begin
                    w_ch_nxt        = hdr_channel(i_byte_in);
                    w_last_word_nxt = hdr_last_word(i_byte_in);
                    w_word_idx_nxt  = '0;
                    w_byte_idx_nxt  = '0;
                    w_timer_nxt     = '0;
                    w_remaining_nxt = RW'((int'(hdr_last_word(i_byte_in)) + 1) * BPW);
                    if (int'(hdr_channel(i_byte_in)) < NCH) begin
                        w_state_nxt = DATA;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end
            end

            DATA: begin
                if (w_valid) begin
                    w_timer_nxt = '0;
                    w_asm_nxt[{r_byte_idx, 3'b000} +: 8] = i_byte_in;
                    if (r_byte_idx == BIW'(BPW - 1)) begin
                        w_word_nxt     = w_asm_nxt;
                        w_byte_idx_nxt = '0;
                        w_state_nxt    = DISPATCH;
                    end else begin
                        w_byte_idx_nxt = r_byte_idx + BIW'(1);
                    end
                end else if (w_timer_inc == TW'(TIMEOUT)) begin
                    w_state_nxt    = HDR;
                    w_pkt_err_nxt  = 1'b1;
                    w_byte_idx_nxt = '0;
                    w_timer_nxt    = '0;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end

            DISPATCH: begin
                // Ready rises the cycle after entry and is held until taken.
                if (w_akn_hit) begin
                    if (r_word_idx == r_last_word) begin
                        w_state_nxt = HDR;
                    end else begin
                        w_word_idx_nxt = r_word_idx + HDR_CNT_W'(1);
                        w_state_nxt    = DATA;
                    end
                end else begin
                    w_ch_ready_nxt = w_ch_mask;
                end
            end

            DROP: begin
                if (w_valid) begin
                    w_timer_nxt = '0;
                    if (r_remaining == RW'(1)) begin
                        w_state_nxt   = HDR;
                        w_pkt_err_nxt = 1'b1;
                    end else begin
                        w_remaining_nxt = r_remaining - RW'(1);
                    end
                end else if (w_timer_inc == TW'(TIMEOUT)) begin
                    w_state_nxt   = HDR;
                    w_pkt_err_nxt = 1'b1;
                    w_timer_nxt   = '0;
                end else begin
                    w_timer_nxt = w_timer_inc;
                end
            end

            default: begin
                w_state_nxt = HDR;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= HDR;
            r_ch        <= '0;
            r_last_word <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_remaining <= '0;
            r_timer     <= '0;
            r_asm       <= '0;
            r_word      <= '0;
            r_ch_ready  <= '0;
            r_pkt_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ch        <= w_ch_nxt;
            r_last_word <= w_last_word_nxt;
            r_word_idx  <= w_word_idx_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_remaining <= w_remaining_nxt;
            r_timer     <= w_timer_nxt;
            r_asm       <= w_asm_nxt;
            r_word      <= w_word_nxt;
            r_ch_ready  <= w_ch_ready_nxt;
            r_pkt_err   <= w_pkt_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_word_dispatcher.sv
// ---------------------------------------------------------------------------
// tb_uart_word_dispatcher
// Self-checking bench for uart_word_dispatcher. A byte driver feeds packets,
// an auto-acknowledging consumer takes offered words, and a packet-level
// reference model predicts the words, acknowledges and error pulses.
// ---------------------------------------------------------------------------
module tb_uart_word_dispatcher;

    localparam int BPW     = 4;
    localparam int NCH     = 4;
    localparam int TIMEOUT = 50;

    typedef struct {
        int               ch;
        logic [BPW*8-1:0] data;
    } expWord_t;

    logic             clock       = 1'b0;
    logic             resetN      = 1'b1;
    logic             inDataReady = 1'b0;
    logic [7:0]       byteIn      = '0;
    logic             outAkn;
    logic [NCH-1:0]   chDataReady;
    logic [NCH-1:0]   chAkn       = '0;
    logic [BPW*8-1:0] wordOut;
    logic             pktErr;
    logic             busy;

    int compared     = 0;
    int mismatched   = 0;
    int cyc          = 0;
    int aknCount     = 0;
    int errCount     = 0;
    int expAkn       = 0;
    int expErr       = 0;
    int lastRaiseCyc = 0;
    int readyRiseCyc = 0;
    int lastAknCyc   = 0;
    int ackMin       = 0;
    int ackMax       = 0;
    int ackDelay     = 0;
    int ackWait      = 0;
    int gapMax       = 1;
    logic autoAck    = 1'b1;
    logic ackedLast  = 1'b0;
    logic [NCH-1:0] prevReady = '0;

    expWord_t   expWords[$];
    logic [7:0] pkt[$];

    uart_word_dispatcher #(
        .BPW     (BPW),
        .NCH     (NCH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk           (clock),
        .i_rst_n         (resetN),
        .i_in_data_ready (inDataReady),
        .i_byte_in       (byteIn),
        .o_out_akn       (outAkn),
        .o_ch_data_ready (chDataReady),
        .i_ch_akn        (chAkn),
        .o_word_out      (wordOut),
        .o_pkt_err       (pktErr),
        .o_busy          (busy)
    );

    // Free-running clock and a cycle counter used for latency measurements.
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Passive monitor: counts acknowledge and error pulses, checks that the
    // ready vector is one-hot, and timestamps ready rising.
    always @(negedge clock) begin
        if (outAkn) begin
            aknCount++;
            lastAknCyc = cyc;
        end
        if (pktErr) errCount++;
        if (chDataReady != '0) begin
            checkOutput("readyOneHot", 64'($onehot(chDataReady)), 64'd1);
            if (prevReady == '0) readyRiseCyc = cyc;
        end
        prevReady = chDataReady;
    end

    // Compare an offered word against the oldest predicted word.
    task automatic checkWord();
        expWord_t e;
        if (expWords.size() == 0) begin
            checkOutput("unexpectedWord", 64'(chDataReady), 64'd0);
            return;
        end
        e = expWords.pop_front();
        checkOutput("wordChannel", 64'(chDataReady), 64'd1 << e.ch);
        checkOutput("wordData", 64'(wordOut), 64'(e.data));
    endtask

    // Consumer: waits a programmable number of cycles after ready, then
    // pulses the acknowledge of the offered channel for one cycle.
    initial begin : consumer
        forever begin
            @(negedge clock);
            if (autoAck) begin
                if (ackedLast) checkOutput("readyDropAfterAck", 64'(chDataReady), 64'd0);
                ackedLast = 1'b0;
                chAkn = '0;
                if (chDataReady != '0) begin
                    if (ackWait < ackDelay) begin
                        ackWait++;
                    end else begin
                        checkWord();
                        chAkn     = chDataReady;
                        ackedLast = 1'b1;
                        ackWait   = 0;
                        ackDelay  = $urandom_range(ackMax, ackMin);
                    end
                end else begin
                    ackWait = 0;
                end
            end
        end
    end

    // Present one byte with a rising edge, hold it until acknowledged, then
    // scramble the bus and idle for a random gap.
    task automatic sendByte(input logic [7:0] b);
        int waited = 0;
        @(negedge clock);
        byteIn       = b;
        inDataReady  = 1'b1;
        lastRaiseCyc = cyc;
        do begin
            @(negedge clock);
            waited++;
        end while (!outAkn && waited < 3000);
        if (!outAkn) checkOutput("byteAknTimeout", 64'd0, 64'd1);
        inDataReady = 1'b0;
        byteIn      = 8'($urandom);
        repeat ($urandom_range(gapMax, 1) - 1) @(negedge clock);
    endtask

    // Reference model plus driver for a complete packet held in pkt[]:
    // predict words for a valid channel or one error for a bad one.
    task automatic applyStimulus(input logic [7:0] hdr);
        int               ch = hdr % 16;
        int               nw = hdr / 16 + 1;
        expWord_t         e;
        logic [BPW*8-1:0] b;
        if (ch < NCH) begin
            for (int w = 0; w < nw; w++) begin
                e.ch   = ch;
                e.data = '0;
                for (int k = 0; k < BPW; k++) begin
                    b      = pkt[w * BPW + k];
                    e.data = e.data + (b << (8 * k));
                end
                expWords.push_back(e);
            end
        end else begin
            expErr++;
        end
        expAkn += 1 + pkt.size();
        sendByte(hdr);
        foreach (pkt[i]) sendByte(pkt[i]);
    endtask

    task automatic randomPacket(input int nBytes);
        pkt = {};
        for (int i = 0; i < nBytes; i++) pkt.push_back(8'($urandom));
    endtask

    // Wait for all predicted words to be taken and the block to go idle,
    // then reconcile the pulse counts with the model.
    task automatic waitIdle(input string tag);
        int waited = 0;
        while ((expWords.size() != 0 || busy) && waited < 5000) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 5000) checkOutput({tag, "IdleTimeout"}, 64'd0, 64'd1);
        repeat (3) @(negedge clock);
        checkOutput({tag, "AknCount"}, 64'(aknCount), 64'(expAkn));
        checkOutput({tag, "ErrCount"}, 64'(errCount), 64'(expErr));
        checkOutput({tag, "PendingWords"}, 64'(expWords.size()), 64'd0);
    endtask

    task automatic pulseReset(input string tag);
        #2 resetN = 1'b0;
        #1 checkOutput(tag, {outAkn, chDataReady, wordOut, pktErr, busy}, '0);
        @(negedge clock);
        resetN = 1'b1;
    endtask

    initial begin : stimulus
        int waited;
        int errAt;
        int nw;
        int ch;
        expWord_t e;

        #1 resetN = 1'b0;
        #2 checkOutput("resetOutputs", {outAkn, chDataReady, wordOut, pktErr, busy}, '0);
        repeat (3) @(negedge clock);
        resetN = 1'b1;

        // Single word to channel 1, acknowledged one cycle after ready.
        $display("[TB] single word to channel 1");
        ackMin = 1; ackMax = 1; ackDelay = 1; gapMax = 2;
        pkt = {8'h11, 8'h22, 8'h33, 8'h44};
        applyStimulus(8'h01);
        waitIdle("t1");
        checkOutput("t1ReadyLatency", 64'(readyRiseCyc - lastRaiseCyc), 64'd3);

        // Four words to channel 0 with a slow consumer; bytes arrive early.
        $display("[TB] four words with slow consumer");
        ackMin = 20; ackMax = 20; ackDelay = 20; gapMax = 1;
        randomPacket(16);
        applyStimulus(8'h30);
        waitIdle("t2");

        // Bad channel: 13 bytes consumed, error only after the last one.
        $display("[TB] bad channel packet");
        ackMin = 0; ackMax = 3; ackDelay = 0; gapMax = 3;
        randomPacket(12);
        expAkn += 13;
        expErr++;
        sendByte(8'h27);
        for (int i = 0; i < 11; i++) sendByte(pkt[i]);
        repeat (2) @(negedge clock);
        checkOutput("t3NoEarlyErr", 64'(errCount), 64'(expErr - 1));
        sendByte(pkt[11]);
        waitIdle("t3");
        randomPacket(4);
        applyStimulus(8'h03);
        waitIdle("t3Next");

        // Timeout mid-word.
        $display("[TB] timeout mid-word");
        expAkn += 3;
        expErr++;
        sendByte(8'h02);
        sendByte(8'($urandom));
        sendByte(8'($urandom));
        waited = 0;
        while (!pktErr && waited < 500) begin
            @(negedge clock);
            waited++;
        end
        errAt = cyc;
        checkOutput("t4ErrSeen", 64'(pktErr), 64'd1);
        checkOutput("t4ErrDelay", 64'(errAt - lastAknCyc), 64'(TIMEOUT));
        checkOutput("t4BusyAfterErr", 64'(busy), 64'd0);
        waitIdle("t4");

        // Reset mid-word and during dispatch.
        $display("[TB] reset mid-packet");
        expAkn += 3;
        sendByte(8'h00);
        sendByte(8'($urandom));
        sendByte(8'($urandom));
        @(negedge clock);
        pulseReset("t5ResetMidWord");
        autoAck = 1'b0;
        chAkn   = '0;
        expAkn += 5;
        sendByte(8'h00);
        for (int i = 0; i < 4; i++) sendByte(8'($urandom));
        waited = 0;
        while (chDataReady == '0 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("t5ReadyBeforeReset", 64'(chDataReady), 64'd1);
        pulseReset("t5ResetDispatch");
        autoAck = 1'b1;
        randomPacket(8);
        applyStimulus(8'h12);
        waitIdle("t5");

        // Acknowledge on another channel must not release the word.
        $display("[TB] acknowledge on wrong channel");
        autoAck = 1'b0;
        chAkn   = '0;
        randomPacket(4);
        applyStimulus(8'h00);
        waited = 0;
        while (chDataReady == '0 && waited < 100) begin
            @(negedge clock);
            waited++;
        end
        chAkn = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            checkOutput("t6HoldOther", 64'(chDataReady), 64'd1);
        end
        e = expWords.pop_front();
        checkOutput("t6Word", 64'(wordOut), 64'(e.data));
        chAkn = 4'b0001;
        @(negedge clock);
        chAkn = '0;
        checkOutput("t6Released", 64'(chDataReady), 64'd0);
        autoAck = 1'b1;
        waitIdle("t6");

        // Random packets, including unknown channels and long packets.
        $display("[TB] random packets");
        ackMin = 0; ackMax = 4; gapMax = 4;
        for (int p = 0; p < 30; p++) begin
            ch = $urandom_range(5, 0);
            nw = ($urandom_range(9, 0) == 0) ? $urandom_range(15, 4) : $urandom_range(3, 0);
            randomPacket((nw + 1) * BPW);
            applyStimulus(8'((nw << 4) | ch));
        end
        waitIdle("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Safety net in case the design wedges somewhere unexpected.
    initial begin : watchdog
        #900000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed %0d checks", compared);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
